// File: rtl/range_bargraph.sv
// Range-sensor bargraph: 4-sample averaging filter driving a 4-LED bar plus a
// status LED, with stale/fault indication by blinking.
//
// state | meaning
// ------+--------------------------------------------------------
// WAIT  | no good sample since reset; bar dark, status LED blinks
// LIVE  | recent good sample; bar shows level, status LED lit
// STALE | no sample for TIMEOUT cycles; bar held, status LED blinks
// FAULT | last sample carried an error code; bar blinks, status dark
module range_bargraph #(
   parameter int TIMEOUT = 1000000,
   parameter int BLINK   = 2000000,
   parameter int TH1     = 50,
   parameter int TH2     = 100,
   parameter int TH3     = 150,
   parameter int TH4     = 200
) (
   input  logic       CLK,
   input  logic       NRST,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic [3:0] in_status,
   output logic       in_ready,
   output logic       D1,
   output logic       D2,
   output logic       D3,
   output logic       D4,
   output logic       D5
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int BW = (BLINK > 1) ? $clog2(BLINK) : 1;

   typedef enum logic [1:0] {S_WAIT, S_LIVE, S_STALE, S_FAULT} state_t;

   state_t          state, state_next;
   logic            pend, pend_good;
   logic [7:0]      pend_data;
   logic [3:0][7:0] hist, hist_next;
   logic            filled, filled_next;
   logic [2:0]      level, level_next;
   logic [3:0]      bar, bar_next;
   logic [TW-1:0]   tmo_cnt, tmo_next;
   logic [BW-1:0]   blink_cnt, blink_next;
   logic            phase, phase_next;
   logic            accept;
   logic [9:0]      sum;
   logic [7:0]      filt;
   logic [3:0]      dbar_next;
   logic            d5_next;

   function automatic logic [2:0] range_level(input logic [7:0] f);
      if (int'(f) < TH1)      return 3'd4;
      else if (int'(f) < TH2) return 3'd3;
      else if (int'(f) < TH3) return 3'd2;
      else if (int'(f) < TH4) return 3'd1;
      else                    return 3'd0;
   endfunction

   function automatic logic [3:0] bar_pattern(input logic [2:0] lvl);
      case (lvl)
         3'd1:    return 4'b0001;
         3'd2:    return 4'b0011;
         3'd3:    return 4'b0111;
         3'd4:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   assign accept = in_valid & in_ready;

   always_comb begin
      tmo_next = tmo_cnt;
      if (accept)
         tmo_next = '0;
      else if (tmo_cnt != TW'(TIMEOUT))
         tmo_next = tmo_cnt + 1'b1;
   end

   always_comb begin
      blink_next = blink_cnt + 1'b1;
      phase_next = phase;
      if (blink_cnt == BW'(BLINK - 1)) begin
         blink_next = '0;
         phase_next = ~phase;
      end
   end

   // Pending sample is folded into the history during the cycle after accept.
   always_comb begin
      hist_next = hist;
      if (pend && pend_good)
         hist_next = filled ? {hist[2:0], pend_data} : {4{pend_data}};
   end

   assign sum  = 10'(hist_next[0]) + 10'(hist_next[1]) + 10'(hist_next[2]) + 10'(hist_next[3]);
   assign filt = sum[9:2];

   always_comb begin
      state_next  = state;
      filled_next = filled;
      level_next  = level;
      bar_next    = bar;
      if (pend) begin
         if (pend_good) begin
            state_next  = S_LIVE;
            filled_next = 1'b1;
            level_next  = range_level(filt);
            bar_next    = bar_pattern(level_next);
         end else begin
            state_next  = S_FAULT;
         end
      end else if (!accept && tmo_next == TW'(TIMEOUT) &&
                   (state == S_LIVE || state == S_FAULT)) begin
         state_next = S_STALE;
      end
   end

   always_comb begin
      dbar_next = 4'b0000;
      d5_next   = 1'b0;
      case (state_next)
         S_WAIT:  d5_next = phase_next;
         S_LIVE: begin
            dbar_next = bar_next;
            d5_next   = 1'b1;
         end
         S_STALE: begin
            dbar_next = bar_next;
            d5_next   = phase_next;
         end
         S_FAULT: dbar_next = {4{phase_next}};
         default: dbar_next = 4'b0000;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!NRST) begin
         state     <= S_WAIT;
         pend      <= 1'b0;
         pend_good <= 1'b0;
         pend_data <= '0;
         hist      <= '0;
         filled    <= 1'b0;
         level     <= '0;
         bar       <= '0;
         tmo_cnt   <= '0;
         blink_cnt <= '0;
         phase     <= 1'b0;
         in_ready  <= 1'b1;
         D1        <= 1'b0;
         D2        <= 1'b0;
         D3        <= 1'b0;
         D4        <= 1'b0;
         D5        <= 1'b0;
      end else begin
         state     <= state_next;
         pend      <= accept;
         pend_good <= ~|in_status;
         pend_data <= in_data;
         hist      <= hist_next;
         filled    <= filled_next;
         level     <= level_next;
         bar       <= bar_next;
         tmo_cnt   <= tmo_next;
         blink_cnt <= blink_next;
         phase     <= phase_next;
         in_ready  <= ~accept;
         D1        <= dbar_next[0];
         D2        <= dbar_next[1];
         D3        <= dbar_next[2];
         D4        <= dbar_next[3];
         D5        <= d5_next;
      end
   end

endmodule

// File: tb/tb_range_bargraph.sv
// Bench for range_bargraph: directed samples; expected {in_ready,D5,D4..D1}
// per cycle are queued by the stimulus and checked by a separate monitor.
module tb_range_bargraph;

   logic       CLK = 1'b0;
   logic       NRST;
   logic       in_valid;
   logic [7:0] in_data;
   logic [3:0] in_status;
   logic       in_ready;
   logic       D1, D2, D3, D4, D5;

   range_bargraph #(
      .TIMEOUT(20),
      .BLINK  (4)
   ) dut (
      .CLK      (CLK),
      .NRST     (NRST),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_status(in_status),
      .in_ready (in_ready),
      .D1       (D1),
      .D2       (D2),
      .D3       (D3),
      .D4       (D4),
      .D5       (D5)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int         cyc;
      logic [5:0] val;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic flush = 1'b0;

   // cycles since the last reset edge
   always @(posedge CLK) cyc <= NRST ? cyc + 1 : 0;

   always @(negedge CLK) begin
      logic [5:0] act;
      exp_t       e;
      act = {in_ready, D5, D4, D3, D2, D1};
      while (sb.size() > 0 && (flush || sb[0].cyc <= cyc)) begin
         e = sb.pop_front();
         checks++;
         if (flush || e.cyc != cyc || act !== e.val) begin
            errors++;
            $display("FAIL %s cyc %0d due %0d got %b want %b", e.name, cyc, e.cyc, act, e.val);
         end
      end
   end

   function automatic logic ph(input int c);
      return ((c / 4) % 2) == 1;
   endfunction

   task automatic push(input int c, input logic [5:0] v, input string n);
      exp_t e;
      e.cyc  = c;
      e.val  = v;
      e.name = n;
      sb.push_back(e);
   endtask

   task automatic goto(input int c);
      int n;
      n = 0;
      while (cyc != c) begin
         @(posedge CLK);
         #1;
         n++;
         if (n > 500) begin
            $display("FAIL goto target %0d stuck at %0d", c, cyc);
            $fatal(1);
         end
      end
   endtask

   task automatic send(input int c, input logic [7:0] d, input logic [3:0] s);
      goto(c);
      in_valid  = 1'b1;
      in_data   = d;
      in_status = s;
      @(posedge CLK);
      #1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_status = '0;
   endtask

   initial begin
      int n;
      NRST      = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_status = '0;
      repeat (3) @(posedge CLK);
      #1;
      NRST = 1'b1;

      // idle after reset: stays WAIT through and past the timeout
      for (int c = 0; c < 24; c++) push(c, {1'b1, ph(c), 4'b0000}, "wait_idle");

      push(24, 6'b100000, "ready_before_first");
      push(25, 6'b000000, "ready_low_filter");
      push(26, 6'b110011, "first_120_lvl2");
      push(27, 6'b110011, "first_120_hold");
      send(24, 8'd120, 4'd0);

      push(29, 6'b010011, "ready_low_40a");
      push(30, 6'b110011, "f100_tie_th2");
      send(28, 8'd40, 4'd0);
      push(31, 6'b010011, "ready_low_40b");
      push(32, 6'b110111, "f80_lvl3");
      send(30, 8'd40, 4'd0);
      push(33, 6'b010111, "ready_low_40c");
      push(34, 6'b110111, "f60_lvl3");
      send(32, 8'd40, 4'd0);
      push(35, 6'b010111, "ready_low_200a");
      push(36, 6'b110111, "f80_after_fill");
      send(34, 8'd200, 4'd0);
      push(37, 6'b010111, "ready_low_200b");
      push(38, 6'b110011, "f120_lvl2");
      send(36, 8'd200, 4'd0);

      // fault sample carries data that would change the result if stored
      push(41, 6'b010011, "fault_filter_cyc");
      push(42, 6'b100000, "fault_ph0");
      push(44, 6'b101111, "fault_ph1");
      push(47, 6'b101111, "fault_ph1_end");
      push(48, 6'b100000, "fault_ph0_again");
      send(40, 8'd255, 4'd6);
      push(49, 6'b000000, "fault_ready_low");
      push(50, 6'b110001, "hist_kept_lvl1");
      send(48, 8'd250, 4'd0);
      push(53, 6'b010001, "ready_low_250");
      push(54, 6'b110000, "f225_lvl0");
      send(52, 8'd250, 4'd0);

      push(60, 6'b110000, "live_lvl0_hold");
      push(61, 6'b010000, "ready_low_20");
      push(62, 6'b110001, "f180_lvl1");
      push(80, 6'b110001, "live_before_expiry");
      push(81, 6'b100001, "stale_ph0");
      push(84, 6'b110001, "stale_ph1");
      push(88, 6'b100001, "stale_ph0_again");
      send(60, 8'd20, 4'd0);

      push(92, 6'b110001, "stale_before_sample");
      push(93, 6'b010001, "stale_filter_cyc");
      push(94, 6'b110011, "f145_relive");
      send(92, 8'd60, 4'd0);

      push(112, 6'b110011, "live_expiry_cyc");
      push(113, 6'b010011, "accept_beats_expiry");
      push(114, 6'b110111, "f97_lvl3");
      push(120, 6'b110111, "timer_cleared");
      send(112, 8'd60, 4'd0);

      // reset during the filter cycle of a sample that would light all LEDs
      goto(122);
      push(123, 6'b010111, "filter_cyc_pre_rst");
      in_valid  = 1'b1;
      in_data   = 8'd10;
      in_status = 4'd0;
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
      NRST     = 1'b0;
      @(posedge CLK);
      #1;
      NRST = 1'b1;
      push(0, 6'b100000, "rst_mid_filter");
      for (int c = 1; c < 4; c++) push(c, 6'b100000, "rst_wait_dark");
      push(4, 6'b110000, "rst_wait_blink");
      push(5, 6'b110000, "rst_wait_blink2");

      goto(6);
      NRST = 1'b0;
      @(posedge CLK);
      #1;
      NRST = 1'b1;
      push(0, 6'b100000, "rst2_vals");
      push(1, 6'b000000, "accept_first_cyc");
      push(2, 6'b110000, "f200_tie_th4");
      send(0, 8'd200, 4'd0);
      push(5, 6'b010000, "ready_low_50");
      push(6, 6'b110001, "f162_shift");
      send(4, 8'd50, 4'd0);

      n = 0;
      while (sb.size() > 0 && n < 50) begin
         @(posedge CLK);
         n++;
      end
      if (sb.size() > 0) flush = 1'b1;
      @(negedge CLK);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
